// File: rtl/traffic_light_monitor_if.sv
// Lamp/sensor observation bundle and monitor status outputs for traffic_light_monitor.
interface traffic_light_monitor_if;
  logic        highway_r;
  logic        highway_y;
  logic        highway_g;
  logic        farm_r;
  logic        farm_y;
  logic        farm_g;
  logic        cow;
  logic        fault_clr;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  phase;
  logic        in_sync;
  logic        cycle_done;
  logic [15:0] cycle_count;

  modport master (
    output highway_r, highway_y, highway_g, farm_r, farm_y, farm_g, cow, fault_clr,
    input  fault, fault_code, phase, in_sync, cycle_done, cycle_count
  );

  modport slave (
    input  highway_r, highway_y, highway_g, farm_r, farm_y, farm_g, cow, fault_clr,
    output fault, fault_code, phase, in_sync, cycle_done, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the highway/farm light controller: decodes lamp phases, checks
// pattern legality, phase order and durations, latches the first fault, counts cycles.
module traffic_light_monitor #(
  parameter int unsigned YELLOW_CYCLES  = 3,
  parameter int unsigned HWY_GREEN_MIN  = 15,
  parameter int unsigned FARM_GREEN_MAX = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_light_monitor_if.slave   bus
);

  localparam logic [7:0] YellowLen = 8'(YELLOW_CYCLES);
  localparam logic [7:0] HwyMin    = 8'(HWY_GREEN_MIN);
  localparam logic [7:0] FarmLimit = 8'(FARM_GREEN_MAX + 1);

  typedef enum logic [1:0] {StSync, StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [5:0]  pat_q, pat_p;
  logic        cow_q, cow_p;
  logic        primed_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic [1:0]  phase_q, phase_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;

  logic       cur_legal, prv_legal;
  logic [1:0] cur_ph, prv_ph;
  logic       changed;
  logic [7:0] cnt_inc;
  logic       f1, f2, f3, f4, f5;
  logic [2:0] code_new;

  // Returns {legal, phase}; bit order is highway R,Y,G then farm R,Y,G.
  function automatic logic [2:0] decode(input logic [5:0] p);
    case (p)
      6'b001100: decode = 3'b100;
      6'b010100: decode = 3'b101;
      6'b100001: decode = 3'b110;
      6'b100010: decode = 3'b111;
      default:   decode = 3'b000;
    endcase
  endfunction

  always_comb begin
    {cur_legal, cur_ph} = decode(pat_q);
    {prv_legal, prv_ph} = decode(pat_p);
    changed = (pat_q != pat_p);
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    f1 = !cur_legal;
    f2 = changed && cur_legal && (!prv_legal || (cur_ph != prv_ph + 2'd1));
    f3 = (changed && prv_legal && prv_ph[0] && (cnt_q != YellowLen)) ||
         (!changed && cur_legal && cur_ph[0] && (cnt_inc > YellowLen));
    f4 = !changed && cur_legal && (cur_ph == 2'd2) && (cnt_inc == FarmLimit);
    f5 = changed && prv_legal && (prv_ph == 2'd0) && ((cnt_q < HwyMin) || !cow_p);

    if      (f1) code_new = 3'd1;
    else if (f2) code_new = 3'd2;
    else if (f3) code_new = 3'd3;
    else if (f4) code_new = 3'd4;
    else if (f5) code_new = 3'd5;
    else         code_new = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    count_d = count_q;
    phase_d = cur_legal ? cur_ph : phase_q;

    unique case (state_q)
      StSync: begin
        cnt_d = 8'd0;
        // pat_q is not a real sample until one edge after reset release.
        if (primed_q) begin
          if (!cur_legal) begin
            state_d = StFault;
            code_d  = 3'd1;
          end else if (cur_ph == 2'd0) begin
            state_d = StRun;
            cnt_d   = 8'd1;
          end
        end
      end
      StRun: begin
        if (code_new != 3'd0) begin
          state_d = StFault;
          code_d  = code_new;
        end else begin
          cnt_d = changed ? 8'd1 : cnt_inc;
          if (changed && (prv_ph == 2'd3)) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
          end
        end
      end
      StFault: ;
      default: state_d = StSync;
    endcase

    // Clear overrides anything detected on the same edge.
    if (bus.fault_clr) begin
      state_d = StSync;
      code_d  = 3'd0;
      cnt_d   = 8'd0;
      done_d  = 1'b0;
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StSync;
      pat_q    <= 6'd0;
      pat_p    <= 6'd0;
      cow_q    <= 1'b0;
      cow_p    <= 1'b0;
      primed_q <= 1'b0;
      cnt_q    <= 8'd0;
      code_q   <= 3'd0;
      phase_q  <= 2'd0;
      done_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      pat_q    <= {bus.highway_r, bus.highway_y, bus.highway_g,
                   bus.farm_r, bus.farm_y, bus.farm_g};
      pat_p    <= pat_q;
      cow_q    <= bus.cow;
      cow_p    <= cow_q;
      primed_q <= 1'b1;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign bus.fault       = (state_q == StFault);
  assign bus.fault_code  = code_q;
  assign bus.phase       = phase_q;
  assign bus.in_sync     = (state_q == StRun);
  assign bus.cycle_done  = done_q;
  assign bus.cycle_count = count_q;

endmodule
